// File: rtl/alu_seq.sv
// Multi-cycle execute-stage ALU: single-cycle ops, shift-add multiply and restoring divide.
// Results and flags are registered; completion is signalled by a one-cycle done pulse.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             s_inm,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             busy,
    output logic             done
);
    localparam int MSB = WIDTH - 1;
    localparam logic [SHW-1:0] LAST_IT = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_PASS = 4'b0000, OP_NOT  = 4'b0001, OP_ADD  = 4'b0010,
                           OP_SUB  = 4'b0011, OP_AND  = 4'b0100, OP_OR   = 4'b0101,
                           OP_NEG  = 4'b0110, OP_NEGS = 4'b0111, OP_ADC  = 4'b1000,
                           OP_SBB  = 4'b1001, OP_SHL  = 4'b1010, OP_SHR  = 4'b1011,
                           OP_SAR  = 4'b1100, OP_MUL  = 4'b1101, OP_DIVU = 4'b1110,
                           OP_REMU = 4'b1111;

    typedef enum logic [1:0] {IDLE, S_MUL, S_DIV} state_t;

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               sinm_q, sinm_d;
    logic               pend_q, pend_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic [WIDTH-1:0]   ex_y, sx, sy;
    logic               ex_c, ex_v;
    logic [WIDTH:0]     sum, dif, sh;
    logic [SHW-1:0]     amt;
    logic               is_multi;

    logic [WIDTH:0]     mul_add, div_sh, div_rem;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_next, div_next;

    logic               upd, new_c, new_v, accept;
    logic [WIDTH-1:0]   new_y;

    assign amt      = b_q[SHW-1:0];
    assign is_multi = (op_q == OP_MUL) ||
                      (((op_q == OP_DIVU) || (op_q == OP_REMU)) && (b_q != '0));

    // Single-cycle result, evaluated from the latched operands one edge after start
    always_comb begin
        ex_y = '0;
        ex_c = 1'b0;
        ex_v = 1'b0;
        sx   = a_q;
        sy   = b_q;
        sum  = '0;
        dif  = '0;
        sh   = '0;
        case (op_q)
            OP_PASS: ex_y = a_q;
            OP_NOT:  ex_y = ~a_q;
            OP_ADD, OP_ADC: begin
                sum  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, (op_q == OP_ADC) & carry_q};
                ex_y = sum[MSB:0];
                ex_c = sum[WIDTH];
                ex_v = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
            end
            OP_SUB, OP_SBB: begin
                sx   = ((op_q == OP_SUB) && sinm_q) ? b_q : a_q;
                sy   = ((op_q == OP_SUB) && sinm_q) ? a_q : b_q;
                // Bit WIDTH of the extended difference is the borrow
                dif  = {1'b0, sx} - {1'b0, sy} - {{WIDTH{1'b0}}, (op_q == OP_SBB) & carry_q};
                ex_y = dif[MSB:0];
                ex_c = dif[WIDTH];
                ex_v = (sx[MSB] != sy[MSB]) && (dif[MSB] != sx[MSB]);
            end
            OP_AND:  ex_y = a_q & b_q;
            OP_OR:   ex_y = a_q | b_q;
            OP_NEG, OP_NEGS: begin
                sx   = ((op_q == OP_NEG) || sinm_q) ? a_q : b_q;
                ex_y = '0 - sx;
                ex_v = (sx == {1'b1, {(WIDTH-1){1'b0}}});
            end
            // The guard bit catches the last bit shifted out and stays 0 for amt=0
            OP_SHL: begin
                sh   = {1'b0, a_q} << amt;
                ex_y = sh[MSB:0];
                ex_c = sh[WIDTH];
            end
            OP_SHR: begin
                sh   = {a_q, 1'b0} >> amt;
                ex_y = sh[WIDTH:1];
                ex_c = sh[0];
            end
            OP_SAR: begin
                sh   = $signed({a_q, 1'b0}) >>> amt;
                ex_y = sh[WIDTH:1];
                ex_c = sh[0];
            end
            OP_DIVU: begin
                ex_y = '1;
                ex_v = 1'b1;
            end
            OP_REMU: begin
                ex_y = a_q;
                ex_v = 1'b1;
            end
            default: ;
        endcase
    end

    // Iteration datapaths sharing prod_q: {acc, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_add  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_add, prod_q[WIDTH-1:1]};
        div_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, b_q});
        div_rem  = div_ge ? (div_sh - {1'b0, b_q}) : div_sh;
        div_next = {div_rem[MSB:0], prod_q[WIDTH-2:0], div_ge};
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        sinm_d  = sinm_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        upd     = 1'b0;
        new_y   = ex_y;
        new_c   = ex_c;
        new_v   = ex_v;

        // A latched op that is about to turn multi-cycle still owns the operand registers
        accept = start && !busy_q && !(pend_q && is_multi);
        pend_d = accept;
        if (accept) begin
            op_d   = op;
            a_d    = a;
            b_d    = b;
            sinm_d = s_inm;
        end

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    if (is_multi) begin
                        state_d = (op_q == OP_MUL) ? S_MUL : S_DIV;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        prod_d  = {{WIDTH{1'b0}}, (op_q == OP_MUL) ? b_q : a_q};
                    end else begin
                        upd    = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                prod_d = mul_next;
                cnt_d  = cnt_q + SHW'(1);
                if (cnt_q == LAST_IT) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    upd     = 1'b1;
                    new_y   = mul_next[MSB:0];
                    new_c   = |mul_next[2*WIDTH-1:WIDTH];
                    new_v   = 1'b0;
                end
            end
            S_DIV: begin
                prod_d = div_next;
                cnt_d  = cnt_q + SHW'(1);
                if (cnt_q == LAST_IT) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    upd     = 1'b1;
                    new_y   = (op_q == OP_REMU) ? div_next[2*WIDTH-1:WIDTH] : div_next[MSB:0];
                    new_c   = 1'b0;
                    new_v   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        y_d     = upd ? new_y : y_q;
        carry_d = upd ? new_c : carry_q;
        ovf_d   = upd ? new_v : ovf_q;
        zero_d  = upd ? (new_y == '0) : zero_q;
        neg_d   = upd ? new_y[MSB] : neg_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sinm_q  <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
            y_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sinm_q  <= sinm_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            y_q     <= y_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign y        = y_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;
    assign negative = neg_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: expected results are queued at issue and popped at done.
module tb_alu_seq;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset, start, s_inm;
    logic [3:0]   op;
    logic [W-1:0] a, b, y;
    logic         carry, overflow, zero, negative, busy, done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string        tag;
        logic [W-1:0] y;
        logic         c;
        logic         v;
        int           lat;
    } exp_t;

    exp_t sb[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .s_inm(s_inm),
        .a(a), .b(b), .y(y), .carry(carry), .overflow(overflow),
        .zero(zero), .negative(negative), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at #1 after a rising edge; start is sampled on the following edge
    task automatic issue(input string tag, input logic [3:0] o, input logic [W-1:0] ia,
                         input logic [W-1:0] ib, input logic si, input logic [W-1:0] ey,
                         input logic ec, input logic ev, input int lat);
        exp_t e;
        e.tag = tag; e.y = ey; e.c = ec; e.v = ev; e.lat = lat;
        sb.push_back(e);
        op = o; a = ia; b = ib; s_inm = si; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); op = 4'($urandom); s_inm = 1'($urandom);
    endtask

    task automatic complete(input int poke_at);
        exp_t e;
        int   lat;
        int   busy_n;
        bit   got;
        e = sb.pop_front();
        lat = 0; busy_n = 0; got = 0;
        chk({e.tag, "_early_done"}, 32'(done), 32'd0);
        for (int k = 1; k <= 40 && !got; k++) begin
            if (k == poke_at) begin
                op = 4'b0010; a = 16'd1; b = 16'd1; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                got = 1;
                lat = k;
            end
        end
        chk({e.tag, "_latency"}, 32'(lat), 32'(e.lat));
        chk({e.tag, "_busy_cycles"}, 32'(busy_n), (e.lat > 1) ? 32'(W) : 32'd0);
        chk({e.tag, "_y"}, 32'(y), 32'(e.y));
        chk({e.tag, "_carry"}, 32'(carry), 32'(e.c));
        chk({e.tag, "_overflow"}, 32'(overflow), 32'(e.v));
        chk({e.tag, "_zero"}, 32'(zero), 32'(e.y == '0));
        chk({e.tag, "_negative"}, 32'(negative), 32'(e.y[W-1]));
    endtask

    task automatic count_dones(input string tag, input int cycles);
        int n;
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        chk(tag, 32'(n), 32'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = '0; s_inm = 1'b0; a = '0; b = '0;
        #1;
        chk("reset_y", 32'(y), 32'd0);
        chk("reset_flags", {28'd0, carry, overflow, zero, negative}, 32'd0);
        chk("reset_busy_done", {30'd0, busy, done}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        issue("add_wrap", 4'b0010, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1); complete(0);
        issue("adc",      4'b1000, 16'h0000, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0, 1); complete(0);
        issue("add_ovf",  4'b0010, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1); complete(0);
        issue("sub_ovf",  4'b0011, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1); complete(0);
        issue("sub_swap", 4'b0011, 16'h0005, 16'h0003, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1); complete(0);
        issue("sbb",      4'b1001, 16'h000A, 16'h0003, 1'b0, 16'h0006, 1'b0, 1'b0, 1); complete(0);
        issue("pass",     4'b0000, 16'h1234, 16'h5555, 1'b0, 16'h1234, 1'b0, 1'b0, 1); complete(0);
        issue("not",      4'b0001, 16'h00FF, 16'h0000, 1'b0, 16'hFF00, 1'b0, 1'b0, 1); complete(0);
        issue("and",      4'b0100, 16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 1'b0, 1'b0, 1); complete(0);
        issue("or",       4'b0101, 16'hF0F0, 16'h0F00, 1'b0, 16'hFFF0, 1'b0, 1'b0, 1); complete(0);
        issue("neg_min",  4'b0110, 16'h8000, 16'h0000, 1'b0, 16'h8000, 1'b0, 1'b1, 1); complete(0);
        issue("negs_b",   4'b0111, 16'h1111, 16'h0005, 1'b0, 16'hFFFB, 1'b0, 1'b0, 1); complete(0);
        issue("shl_mask", 4'b1010, 16'h8001, 16'h0011, 1'b0, 16'h0002, 1'b1, 1'b0, 1); complete(0);
        issue("shl_zero", 4'b1010, 16'h8001, 16'h0000, 1'b0, 16'h8001, 1'b0, 1'b0, 1); complete(0);
        issue("shr",      4'b1011, 16'h0003, 16'h0001, 1'b0, 16'h0001, 1'b1, 1'b0, 1); complete(0);
        issue("sar",      4'b1100, 16'h8004, 16'h0002, 1'b0, 16'hE001, 1'b0, 1'b0, 1); complete(0);

        issue("mul_300",  4'b1101, 16'd300,  16'd300,  1'b0, 16'h5F90, 1'b1, 1'b0, W + 1); complete(5);
        count_dones("mul_ignored_start_done", 4);
        issue("mul_max",  4'b1101, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 1'b1, 1'b0, W + 1); complete(0);
        issue("divu",     4'b1110, 16'd100,  16'd7,    1'b0, 16'd14,   1'b0, 1'b0, W + 1); complete(0);
        issue("divu_z",   4'b1110, 16'h1234, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1); complete(0);
        issue("remu_z",   4'b1111, 16'h1234, 16'h0000, 1'b0, 16'h1234, 1'b0, 1'b1, 1); complete(0);
        issue("remu",     4'b1111, 16'd100,  16'd7,    1'b0, 16'd2,    1'b0, 1'b0, W + 1); complete(0);

        // Abort a multiply after five iterations; y holds 2 from the previous op
        op = 4'b1101; a = 16'd300; b = 16'd300; s_inm = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_y", 32'(y), 32'd0);
        chk("abort_flags", {28'd0, carry, overflow, zero, negative}, 32'd0);
        chk("abort_busy_done", {30'd0, busy, done}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        count_dones("abort_no_done", 25);

        issue("adc_after_reset", 4'b1000, 16'd2, 16'd3, 1'b0, 16'd5, 1'b0, 1'b0, 1); complete(0);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
